// File: rtl/mux4_arb_rr_if.sv
// Producer/consumer bundle for the round-robin 4:1 mux arbiter.
// master = producers and consumer side, slave = arbiter side.
interface mux4_arb_rr_if #(
  parameter int unsigned N = 4
);
  logic [3:0]   req;
  logic [3:0]   lock;
  logic [N-1:0] InA;
  logic [N-1:0] InB;
  logic [N-1:0] InC;
  logic [N-1:0] InD;
  logic         out_ready;
  logic [3:0]   gnt;
  logic [1:0]   S;
  logic [N-1:0] Out;
  logic         out_valid;
  logic [1:0]   out_src;

  modport master (
    output req, lock, InA, InB, InC, InD, out_ready,
    input  gnt, S, Out, out_valid, out_src
  );

  modport slave (
    input  req, lock, InA, InB, InC, InD, out_ready,
    output gnt, S, Out, out_valid, out_src
  );
endinterface

// File: rtl/mux4_arb_rr.sv
// Round-robin arbiter sharing a quad 4:1 mux, with a one-entry valid/ready output register.
// Optional locked bursts are built only when ARB_LOCK_EN is defined.

// Quad 4:1 mux datapath: selects one of four N-bit words.
module quad_mux4 #(
  parameter int unsigned N = 4
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_c,
  input  logic [N-1:0] in_d,
  output logic [N-1:0] out_c
);
  always_comb begin
    out_c = in_a;
    unique case (sel)
      2'd0:    out_c = in_a;
      2'd1:    out_c = in_b;
      2'd2:    out_c = in_c;
      default: out_c = in_d;
    endcase
  end
endmodule

module mux4_arb_rr #(
  parameter int unsigned N = 4
) (
  input logic           clk,
  input logic           rst_n,
  mux4_arb_rr_if.slave  bus
);
  localparam int unsigned NSRC = 4;
  localparam int unsigned SW   = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   ptr, ptr_nxt;
  logic [N-1:0]    data_q, data_nxt;
  logic [SW-1:0]   src_q, src_nxt;

  logic [SW-1:0]   winner_c;
  logic            any_req_c;
  logic            can_load_c;
  logic            load_c;
  logic [SW-1:0]   sel_c;
  logic [NSRC-1:0] gnt_c;
  logic [N-1:0]    mux_c;

  // Round-robin search from ptr+1; the highest offset is scanned first so the nearest requester wins.
  always_comb begin
    winner_c  = ptr;
    any_req_c = |bus.req;
    for (int k = NSRC; k >= 1; k--) begin
      if (bus.req[ptr + SW'(k)]) winner_c = ptr + SW'(k);
    end
`ifdef ARB_LOCK_EN
    // Locked burst: the last winner keeps the grant while it still requests with lock.
    if (bus.req[ptr] && bus.lock[ptr]) winner_c = ptr;
`endif
  end

  assign can_load_c = (state == EMPTY) || bus.out_ready;
  assign load_c     = can_load_c && any_req_c;
  assign sel_c      = any_req_c ? winner_c : ptr;
  assign gnt_c      = load_c ? (NSRC'(1) << winner_c) : '0;

  quad_mux4 #(.N(N)) u_mux (
    .sel   (sel_c),
    .in_a  (bus.InA),
    .in_b  (bus.InB),
    .in_c  (bus.InC),
    .in_d  (bus.InD),
    .out_c (mux_c)
  );

  // State, pointer and output word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      ptr    <= SW'(NSRC - 1);
      data_q <= '0;
      src_q  <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      data_q <= data_nxt;
      src_q  <= src_nxt;
    end
  end

  // Next-state: load when room exists, drain to EMPTY when consumed with nothing to replace it.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    data_nxt  = data_q;
    src_nxt   = src_q;
    unique case (state)
      EMPTY: begin
        if (load_c) state_nxt = FULL;
      end
      FULL: begin
        if (bus.out_ready && !any_req_c) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    if (load_c) begin
      ptr_nxt  = winner_c;
      data_nxt = mux_c;
      src_nxt  = winner_c;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.S         = sel_c;
  assign bus.Out       = data_q;
  assign bus.out_valid = (state == FULL);
  assign bus.out_src   = src_q;
endmodule

// File: tb/tb_mux4_arb_rr.sv
// Directed bench for mux4_arb_rr: reset, rotation, backpressure, mid-stream reset, lock.
module tb_mux4_arb_rr;
  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mux4_arb_rr_if #(.N(N)) bus ();

  mux4_arb_rr #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.lock      = 4'b0000;
    bus.out_ready = 1'b0;
    bus.InA = 4'h1; bus.InB = 4'h2; bus.InC = 4'h3; bus.InD = 4'h4;

    // Reset then idle
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out",   32'(bus.Out),       32'd0);
    chk("rst_src",   32'(bus.out_src),   32'd0);
    chk("rst_gnt",   32'(bus.gnt),       32'd0);
    chk("rst_sel",   32'(bus.S),         32'd3);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_gnt",   32'(bus.gnt),       32'd0);

    // Fair rotation: grants 0,1,2,3,0 with words 1,2,3,4,1
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("rot0_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    chk("rot0_out", 32'(bus.Out), 32'h1);
    chk("rot0_vld", 32'(bus.out_valid), 32'd1);
    chk("rot1_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    chk("rot1_out", 32'(bus.Out), 32'h2);
    chk("rot2_gnt", 32'(bus.gnt), 32'b0100);
    tick();
    chk("rot2_out", 32'(bus.Out), 32'h3);
    chk("rot3_gnt", 32'(bus.gnt), 32'b1000);
    tick();
    chk("rot3_out", 32'(bus.Out), 32'h4);
    chk("rot3_src", 32'(bus.out_src), 32'd3);
    chk("rot4_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    chk("rot4_out", 32'(bus.Out), 32'h1);
    chk("rot4_vld", 32'(bus.out_valid), 32'd1);
    // two more grants (sources 1,2) so Out=3 before stalling
    tick();
    tick();
    chk("pre_bp_out", 32'(bus.Out), 32'h3);

    // Backpressure: 5 stalled cycles in FULL
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_gnt", 32'(bus.gnt), 32'd0);
      tick();
      chk("bp_out", 32'(bus.Out), 32'h3);
      chk("bp_vld", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_gnt", 32'(bus.gnt), 32'b1000);
    tick();
    chk("bp_rel_out", 32'(bus.Out), 32'h4);
    chk("bp_rel_src", 32'(bus.out_src), 32'd3);

    // Drain with no request: FULL -> EMPTY, Out holds
    bus.req = 4'b0000;
    #1;
    chk("drain_gnt", 32'(bus.gnt), 32'd0);
    chk("drain_sel", 32'(bus.S), 32'd3);
    tick();
    chk("drain_vld", 32'(bus.out_valid), 32'd0);
    chk("drain_out", 32'(bus.Out), 32'h4);

    // Single request from source C
    bus.InC = 4'hA;
    bus.req = 4'b0100;
    #1;
    chk("single_gnt", 32'(bus.gnt), 32'b0100);
    chk("single_sel", 32'(bus.S), 32'd2);
    tick();
    chk("single_out", 32'(bus.Out), 32'hA);
    chk("single_vld", 32'(bus.out_valid), 32'd1);
    chk("single_src", 32'(bus.out_src), 32'd2);

    // Mid-stream reset while FULL
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(bus.out_valid), 32'd0);
    chk("mrst_out", 32'(bus.Out), 32'd0);
    chk("mrst_sel", 32'(bus.S), 32'd3);
    #1;
    rst_n = 1'b1;
    tick();
    bus.req = 4'b1010;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    chk("post_rst_out", 32'(bus.Out), 32'h2);
    chk("post_rst_src", 32'(bus.out_src), 32'd1);
    chk("post_rst_gnt2", 32'(bus.gnt), 32'b1000);
    tick();
    chk("post_rst_out2", 32'(bus.Out), 32'h4);

    // Lock hint: ptr=3 now, req=0011, lock=0001
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    #1;
    chk("lk0_gnt", 32'(bus.gnt), 32'b0001);
    tick();
`ifdef ARB_LOCK_EN
    chk("lk1_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    chk("lk2_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    chk("lk2_out", 32'(bus.Out), 32'h1);
    bus.lock = 4'b0000;
    #1;
    chk("lk_rel_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    chk("lk_rel_out", 32'(bus.Out), 32'h2);
`else
    chk("nolk1_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    chk("nolk1_out", 32'(bus.Out), 32'h2);
    chk("nolk2_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    chk("nolk2_out", 32'(bus.Out), 32'h1);
`endif
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    tick();
    chk("end_vld", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux4_arb_rr.md
# mux4_arb_rr

Round-robin arbiter that shares one 4-to-1 N-bit mux datapath among four requesters. It picks one requesting source per cycle, drives the mux select, and captures the selected word into a single-entry output register. The register is drained through a valid/ready handshake. The block sits between four producer ports and one downstream consumer, and instantiates the existing quad 4-1 mux as its datapath.

## Interface
- N, default 4: data width of every input and output word.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-source request; req[i] means InX_i holds a valid word (i=0..3 maps to A..D).
- lock  in  4  per-source lock hint; used only when ARB_LOCK_EN is defined.
- InA, InB, InC, InD  in  N each  source data words.
- out_ready  in  1  consumer accepts Out this cycle when high with out_valid.
- gnt  out  4  one-hot accept pulse; gnt[i]=1 means source i's word is captured at this edge.
- S  out  2  mux select for the current winner (combinational).
- Out  out  N  registered output word.
- out_valid  out  1  Out holds an unconsumed word.
- out_src  out  2  index of the source that produced Out.

## Operation
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = !out_valid || out_ready.
- Arbitration runs every cycle:
  - Search order starts at ptr+1 and wraps modulo 4 (ptr = last winner).
  - The winner is the first i with req[i]=1.
  - any_req = |req.
- When can_load && any_req:
  - gnt[winner]=1.
  - Out <= mux output with S=winner.
  - out_src <= winner.
  - out_valid <= 1.
  - ptr <= winner.
- When can_load && !any_req: out_valid <= 0, and Out/out_src hold.
- When !can_load: gnt=0; Out, out_src, out_valid and ptr all hold.
- S equals the winner index when any_req=1. Otherwise S holds the last winner (ptr).
- gnt is combinational and at most one bit is set. It is 0 whenever !can_load or !any_req.
- Transitions:
  - EMPTY -> FULL on load.
  - FULL -> FULL on simultaneous drain and load (back-to-back, 1 word/cycle).
  - FULL -> EMPTY on drain with no request.
- Requesters must hold req and data until they see gnt. Dropping req before gnt is legal, and that source is simply not considered.

## Timing
- Reset values (asynchronous, on rst_n low):
  - out_valid=0, Out=0, out_src=0.
  - ptr=3, so source 0 has first priority.
  - gnt=0 and S=3 while req=0.
- Latency: a word granted at edge k appears on Out with out_valid=1 after edge k (1 cycle).
- Throughput: 1 word/cycle while out_ready=1 and any_req=1.
- Fairness: with all four req held high, the grant order is 0,1,2,3,0,... Each source waits at most 3 grants.
- Simultaneous out_ready and load in FULL: the old word is consumed and the new word is captured at the same edge, with no bubble.
- Backpressure: with out_ready=0 in FULL, Out is stable and gnt stays 0 for any length of stall.
- Reset asserted mid-transfer: the pending word is discarded, out_valid drops immediately (asynchronously) and ptr returns to 3. The first grant after rst_n rises uses source-0-first order.

## Configuration
- Macro ARB_LOCK_EN.
- Defined:
  - If req[ptr] && lock[ptr] when a load occurs, source ptr wins regardless of rotation, giving a locked burst.
  - Rotation resumes from ptr once lock[ptr] or req[ptr] drops.
- Undefined:
  - The lock input is ignored and arbitration is pure round-robin.
  - No lock-related logic is synthesized.

## Test plan
- Reset then idle: rst_n=0, then 1 with req=0 -> out_valid=0, Out=0, out_src=0, gnt=0.
- Single request: req=4'b0100, InC=4'hA, out_ready=1 -> gnt=4'b0100 at edge 1; next cycle Out=4'hA, out_valid=1, out_src=2.
- Fair rotation: req=4'b1111 held, out_ready=1, InA..InD=1,2,3,4 -> Out sequence 1,2,3,4,1 on consecutive cycles, with no idle cycles.
- Backpressure: FULL with Out=4'h3, out_ready=0 for 5 cycles, req=4'b1111 -> Out=4'h3 stable and gnt=0 throughout. Raising out_ready gives the next source's word one cycle later.
- Reset mid-stream: rst_n pulsed low while out_valid=1 -> out_valid=0 immediately. With req=4'b1010 after release, source 1 is granted first.
- Lock (ARB_LOCK_EN defined): req=4'b0011, lock=4'b0001, out_ready=1 -> source 0 is granted on 3 consecutive cycles. After lock drops, source 1 is granted next.
